// File: rtl/game_pkg.sv
// Shared game-level types and constants for the obstacle datapath blocks.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int          D_WIDTH      = 640;
    localparam int          D_HEIGHT     = 480;
    localparam int          MAX_SPEED    = 4;
    localparam int          SPEEDUP_STEP = 8;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR; advances every cycle, reloads SEED on reset.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_state
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_state <= SEED;
        end else if (o_state[0]) begin
            o_state <= (o_state >> 1) ^ LFSR_TAPS;
        end else begin
            o_state <= o_state >> 1;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot pool, spawn cadence, scoring and IDLE/RUN/OVER game FSM.
// Optional macro OBSTACLE_SPEEDUP_EN: speed steps up every SPEEDUP_STEP retirements.
module obstacle_scheduler #(
    parameter int          N_OBS     = 4,
    parameter int          H_WIDTH   = 20,
    parameter int          H_HEIGHT  = 15,
    parameter int          D_WIDTH   = game_pkg::D_WIDTH,
    parameter int          D_HEIGHT  = game_pkg::D_HEIGHT,
    parameter int          SPAWN_GAP = 160,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ani_stb,
    input  logic                 i_start,
    input  logic                 i_collide,
    output logic [12*N_OBS-1:0]  o_x,
    output logic [12*N_OBS-1:0]  o_y,
    output logic [N_OBS-1:0]     o_active,
    output logic [1:0]           o_state,
    output logic [15:0]          o_score
);
    import game_pkg::*;

    localparam int          GAP_W   = $clog2(SPAWN_GAP);
    localparam logic [11:0] SPAWN_X = 12'(D_WIDTH + H_WIDTH - 1);
    localparam logic [9:0]  Y_RANGE = 10'(D_HEIGHT - 2 * H_HEIGHT);
    localparam logic [11:0] Y_BASE  = 12'(H_HEIGHT);

    state_t            state_q;
    logic [15:0]       score_q;
    logic [GAP_W-1:0]  gap_q;
    logic [2:0]        speed;
    logic [15:0]       lfsr_q;
    logic              lfsr_unused;
    logic              act_q [N_OBS];
    logic [11:0]       x_q   [N_OBS];
    logic [11:0]       y_q   [N_OBS];
    logic [N_OBS-1:0]  free_oh;
    logic [N_OBS-1:0]  retire;
    logic              run_stb;
    logic              clear_slots;
    logic              wrap;
    logic [3:0]        ret_cnt;
    logic [16:0]       score_sum;
    logic [15:0]       score_nxt;
    logic [9:0]        r_ext;
    logic [9:0]        r_sub;
    logic [11:0]       spawn_y;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_state (lfsr_q)
    );

    // Collision outranks a same-cycle strobe, so it suppresses all slot updates.
    assign run_stb     = (state_q == ST_RUN) && i_ani_stb && !i_collide;
    assign clear_slots = (state_q == ST_IDLE) || ((state_q == ST_OVER) && i_start);
    assign wrap        = (gap_q == GAP_W'(SPAWN_GAP - 1));
    assign free_oh     = ~o_active & (o_active + N_OBS'(1));

    assign r_ext       = {1'b0, lfsr_q[8:0]};
    assign r_sub       = (r_ext >= Y_RANGE) ? (r_ext - Y_RANGE) : r_ext;
    assign spawn_y     = Y_BASE + {2'b00, r_sub};
    assign lfsr_unused = ^lfsr_q[15:9];

    always_comb begin
        ret_cnt = '0;
        for (int unsigned k = 0; k < N_OBS; k++) begin
            ret_cnt = ret_cnt + 4'(retire[k]);
        end
    end

    assign score_sum = {1'b0, score_q} + 17'(ret_cnt);
    assign score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

`ifdef OBSTACLE_SPEEDUP_EN
    logic [2:0] speed_q;
    logic       crossed;

    assign crossed = (score_nxt / 16'(SPEEDUP_STEP)) != (score_q / 16'(SPEEDUP_STEP));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            speed_q <= 3'd1;
        end else if ((state_q == ST_IDLE) && i_start) begin
            speed_q <= 3'd1;
        end else if (run_stb && crossed && (speed_q < 3'(MAX_SPEED))) begin
            speed_q <= speed_q + 3'd1;
        end
    end

    assign speed = speed_q;
`else
    assign speed = 3'd1;
`endif

    // Every slot decides from pre-strobe state; free_oh only selects inactive slots.
    for (genvar k = 0; k < N_OBS; k++) begin : g_slot
        assign retire[k] = act_q[k] && (x_q[k] <= {9'b0, speed});

        always_ff @(posedge i_clk) begin
            if (i_rst || clear_slots) begin
                act_q[k] <= 1'b0;
                x_q[k]   <= '0;
                y_q[k]   <= '0;
            end else if (run_stb) begin
                if (retire[k]) begin
                    act_q[k] <= 1'b0;
                    x_q[k]   <= '0;
                end else if (act_q[k]) begin
                    x_q[k] <= x_q[k] - {9'b0, speed};
                end else if (wrap && free_oh[k]) begin
                    act_q[k] <= 1'b1;
                    x_q[k]   <= SPAWN_X;
                    y_q[k]   <= spawn_y;
                end
            end
        end

        assign o_x[12*k +: 12] = x_q[k];
        assign o_y[12*k +: 12] = y_q[k];
        assign o_active[k]     = act_q[k];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            score_q <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_RUN;
                        score_q <= '0;
                        gap_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (i_collide) begin
                        state_q <= ST_OVER;
                    end else if (i_ani_stb) begin
                        gap_q   <= wrap ? '0 : gap_q + GAP_W'(1);
                        score_q <= score_nxt;
                    end
                end
                ST_OVER: begin
                    if (i_start) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_state = state_q;
    assign o_score = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: behavioural model + scoreboard, vector table, corner sequences.
module tb_obstacle_scheduler;

    localparam int N      = 4;
    localparam int HW     = 20;
    localparam int HH     = 15;
    localparam int DW     = 640;
    localparam int DH     = 480;
    localparam int GAP    = 160;
    localparam int YR     = DH - 2 * HH;
    localparam int SPX    = DW + HW - 1;
`ifdef OBSTACLE_SPEEDUP_EN
    localparam int EXP_STEP = 2;
`else
    localparam int EXP_STEP = 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stb = 1'b0;
    logic              start = 1'b0;
    logic              collide = 1'b0;
    logic [12*N-1:0]   o_x;
    logic [12*N-1:0]   o_y;
    logic [N-1:0]      o_active;
    logic [1:0]        o_state;
    logic [15:0]       o_score;

    obstacle_scheduler #(
        .N_OBS     (N),
        .H_WIDTH   (HW),
        .H_HEIGHT  (HH),
        .D_WIDTH   (DW),
        .D_HEIGHT  (DH),
        .SPAWN_GAP (GAP),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ani_stb (stb),
        .i_start   (start),
        .i_collide (collide),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_active  (o_active),
        .o_state   (o_state),
        .o_score   (o_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      st;
        logic [N-1:0]    act;
        logic [15:0]     score;
        logic [12*N-1:0] x;
        logic [12*N-1:0] y;
    } snap_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic       collide;
        logic       stb;
        logic [1:0] exp_st;
        logic [N-1:0] exp_act;
        logic [15:0] exp_score;
    } vec_t;

    snap_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Behavioural model state
    logic [11:0] m_x [N];
    logic [11:0] m_y [N];
    logic [N-1:0] m_act = '0;
    int          m_st = 0;
    int          m_score = 0;
    int          m_gap = 0;
    int          m_spd = 1;
    logic [15:0] m_lfsr = 16'hACE1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [11:0] slot_x(input int k);
        return o_x[12*k +: 12];
    endfunction

    function automatic logic [11:0] slot_y(input int k);
        return o_y[12*k +: 12];
    endfunction

    task automatic clear_model_slots();
        for (int k = 0; k < N; k++) begin
            m_x[k] = '0;
            m_y[k] = '0;
        end
        m_act = '0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic c, input logic a);
        logic [15:0] nl;
        int free_k;
        int ret;
        int old_sc;
        int yv;
        if (r) begin
            clear_model_slots();
            m_st = 0; m_score = 0; m_gap = 0; m_spd = 1; m_lfsr = 16'hACE1;
            return;
        end
        nl = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        case (m_st)
            0: begin
                clear_model_slots();
                if (s) begin
                    m_st = 1; m_score = 0; m_gap = 0; m_spd = 1;
                end
            end
            1: begin
                if (c) begin
                    m_st = 2;
                end else if (a) begin
                    free_k = -1;
                    for (int k = N - 1; k >= 0; k--) if (!m_act[k]) free_k = k;
                    ret = 0;
                    for (int k = 0; k < N; k++) begin
                        if (m_act[k]) begin
                            if (int'(m_x[k]) > m_spd) begin
                                m_x[k] = 12'(int'(m_x[k]) - m_spd);
                            end else begin
                                m_act[k] = 1'b0;
                                m_x[k] = '0;
                                ret++;
                            end
                        end
                    end
                    if (m_gap == GAP - 1) begin
                        m_gap = 0;
                        if (free_k >= 0) begin
                            yv = int'(m_lfsr[8:0]);
                            if (yv >= YR) yv -= YR;
                            m_act[free_k] = 1'b1;
                            m_x[free_k] = 12'(SPX);
                            m_y[free_k] = 12'(HH + yv);
                        end
                    end else begin
                        m_gap++;
                    end
                    old_sc = m_score;
                    m_score = (m_score + ret > 65535) ? 65535 : m_score + ret;
`ifdef OBSTACLE_SPEEDUP_EN
                    if ((m_score / 8) != (old_sc / 8) && m_spd < 4) m_spd++;
`else
                    if (old_sc < 0) m_spd = 1;
`endif
                end
            end
            default: begin
                if (s) begin
                    m_st = 0;
                    clear_model_slots();
                end
            end
        endcase
        m_lfsr = nl;
    endtask

    function automatic snap_t model_snap();
        snap_t sn;
        sn.st = 2'(m_st);
        sn.act = m_act;
        sn.score = 16'(m_score);
        for (int k = 0; k < N; k++) begin
            sn.x[12*k +: 12] = m_x[k];
            sn.y[12*k +: 12] = m_y[k];
        end
        return sn;
    endfunction

    task automatic cycle(input logic r, input logic s, input logic c, input logic a);
        snap_t e;
        rst = r; start = s; collide = c; stb = a;
        model_step(r, s, c, a);
        q.push_back(model_snap());
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("cyc_state",  64'(o_state),  64'(e.st));
        chk("cyc_active", 64'(o_active), 64'(e.act));
        chk("cyc_score",  64'(o_score),  64'(e.score));
        chk("cyc_x",      64'(o_x),      64'(e.x));
        chk("cyc_y",      64'(o_y),      64'(e.y));
    endtask

    task automatic strobe();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[16];
        int   pick;
        logic [11:0] px;
        logic [N-1:0] pre_act;
        logic [12*N-1:0] pre_x;

        clear_model_slots();
        //           rst   start collide stb   state act score
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 16'd0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 16'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, '0, 16'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, '0, 16'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, '0, 16'd0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, '0, 16'd0};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, '0, 16'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, '0, 16'd0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, '0, 16'd0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, 16'd0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, '0, 16'd0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, '0, 16'd0};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, '0, 16'd0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 16'd0};
        vt[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, '0, 16'd0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, '0, 16'd0};

        for (int i = 0; i < 16; i++) begin
            cycle(vt[i].rst, vt[i].start, vt[i].collide, vt[i].stb);
            chk($sformatf("vec%0d_state", i), 64'(o_state), 64'(vt[i].exp_st));
            chk($sformatf("vec%0d_active", i), 64'(o_active), 64'(vt[i].exp_act));
            chk($sformatf("vec%0d_score", i), 64'(o_score), 64'(vt[i].exp_score));
        end

        // Fresh game: spawn cadence, movement, pool exhaustion, retirement
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_state", 64'(o_state), 64'd1);
        chk("start_active", 64'(o_active), 64'd0);
        for (int s = 1; s <= 159; s++) strobe();
        chk("no_spawn_159", 64'(o_active), 64'd0);
        strobe();
        chk("spawn160_act0", 64'(o_active[0]), 64'd1);
        chk("spawn160_x0", 64'(slot_x(0)), 64'd659);
        chk("spawn160_y0_range", 64'(slot_y(0) >= 12'd15 && slot_y(0) <= 12'd464), 64'd1);
        strobe();
        chk("move161_x0", 64'(slot_x(0)), 64'd658);
        for (int s = 162; s <= 640; s++) strobe();
        chk("pool_full_640", 64'(o_active), 64'hF);
        chk("spawn640_x3", 64'(slot_x(3)), 64'd659);
        for (int s = 641; s <= 800; s++) strobe();
        chk("skip_800_active", 64'(o_active), 64'hF);
        chk("skip_800_x3", 64'(slot_x(3)), 64'd499);
        for (int s = 801; s <= 818; s++) strobe();
        chk("pre_retire_score", 64'(o_score), 64'd0);
        chk("pre_retire_x0", 64'(slot_x(0)), 64'd1);
        strobe();
        chk("retire819_act0", 64'(o_active[0]), 64'd0);
        chk("retire819_x0", 64'(slot_x(0)), 64'd0);
        chk("retire819_score", 64'(o_score), 64'd1);
        for (int s = 820; s <= 960; s++) strobe();
        chk("respawn960_act0", 64'(o_active[0]), 64'd1);
        chk("respawn960_x0", 64'(slot_x(0)), 64'd659);

        // Run until eight retirements, then measure one strobe of motion
        for (int g = 0; g < 3000 && m_score < 8; g++) strobe();
        chk("score_reached_8", 64'(o_score), 64'd8);
        pick = -1;
        for (int k = N - 1; k >= 0; k--) if (m_act[k] && m_x[k] > 12'd8) pick = k;
        if (pick < 0) begin
            chk("speed_slot_found", 64'd0, 64'd1);
        end else begin
            px = m_x[pick];
            strobe();
            chk("speed_step_x", 64'(slot_x(pick)), 64'(px - 12'(EXP_STEP)));
        end

        // Collision wins over a same-cycle strobe and freezes the field
        pre_act = m_act;
        pre_x = model_snap().x;
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("collide_state", 64'(o_state), 64'd2);
        chk("collide_x_frozen", 64'(o_x), 64'(pre_x));
        chk("collide_act_frozen", 64'(o_active), 64'(pre_act));
        strobe();
        strobe();
        chk("over_x_frozen", 64'(o_x), 64'(pre_x));
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk("over_to_idle_state", 64'(o_state), 64'd0);
        chk("over_to_idle_active", 64'(o_active), 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_hold_state", 64'(o_state), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("final_reset_score", 64'(o_score), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Game-level controller for the scrolling obstacle datapath. It owns a pool of N_OBS obstacle slots and spawns them at the right screen edge on a fixed frame cadence, with a pseudo-random vertical centre. It moves the slots left once per animation strobe, retires them at the left edge, counts score and runs the IDLE/RUN/OVER game state machine. It sits between the frame-strobe generator, the collision checker and the VGA draw logic, which consumes the packed centre coordinates.

## Interface
Parameters:
- N_OBS, 4: number of obstacle slots (1–8).
- H_WIDTH, 20: half obstacle width, in pixels.
- H_HEIGHT, 15: half obstacle height, in pixels.
- D_WIDTH, 640: display width.
- D_HEIGHT, 480: display height.
- SPAWN_GAP, 160: animation frames between spawn attempts (≥2).
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- i_clk, in, 1: base clock. Single clock domain.
- i_rst, in, 1: reset, synchronous, active-high.
- i_ani_stb, in, 1: one-cycle pulse, once per frame.
- i_start, in, 1: level-sampled start/restart request.
- i_collide, in, 1: player–obstacle overlap flag from the collision checker.
- o_x, out, 12*N_OBS: slot centre x; slot k occupies bits [12k+11:12k].
- o_y, out, 12*N_OBS: slot centre y, packed the same way as o_x.
- o_active, out, N_OBS: slot k is valid and must be drawn.
- o_state, out, 2: 0 = IDLE, 1 = RUN, 2 = OVER.
- o_score, out, 16: number of obstacles retired since the last start. Saturates at 16'hFFFF.

## Operation
- **Reset values:** o_x = 0, o_y = 0, o_active = 0, o_state = IDLE, o_score = 0, gap counter = 0, LFSR = LFSR_SEED, speed = 1.
- **LFSR:** 16-bit Galois, polynomial 0xB400. It advances every i_clk cycle in every state, so spawn positions depend on when the player presses start.
- **IDLE:**
  - All slots are held inactive.
  - When i_start = 1: go to RUN, clear o_score, clear the gap counter, set speed to 1.
- **RUN:** on each i_ani_stb, all of the following evaluate on the same pre-strobe register values:
  - **Move:** every active slot with x > speed gets x ← x − speed.
  - **Retire:** an active slot with x ≤ speed gets active ← 0 and x ← 0, and o_score increments by the number of slots retired on that strobe.
  - **Spawn:**
    - When the gap counter = SPAWN_GAP−1, the counter wraps to 0. Otherwise it increments.
    - On a wrap, the lowest-index slot that was inactive before this strobe gets active ← 1, x ← D_WIDTH + H_WIDTH − 1, and y ← H_HEIGHT + r.
    - r = LFSR[8:0], minus Y_RANGE if LFSR[8:0] ≥ Y_RANGE, where Y_RANGE = D_HEIGHT − 2*H_HEIGHT.
    - Exactly one conditional subtract is used. It is legal only while 256 ≤ Y_RANGE ≤ 511.
    - If no slot is free, the spawn is skipped silently. The counter still wraps.
    - A slot retired on this strobe cannot be respawned on the same strobe.
- **Collision:** when i_collide = 1 in RUN, go to OVER on the next clock.
  - This takes priority over a same-cycle i_ani_stb: no move, retire or spawn happens on that cycle.
- **OVER:**
  - Slot positions, o_active and o_score are frozen, so the crash remains drawn.
  - i_start = 1 goes to IDLE for exactly one cycle. That cycle clears all slots. The following cycle is evaluated from IDLE.
- **Outside RUN:** i_ani_stb has no effect.
- **Mid-operation reset:** i_rst overrides everything in the same cycle and returns all outputs to their reset values.

## Timing
- All outputs are registered.
- Effects of an i_ani_stb sampled in cycle n are visible in cycle n+1.
- State changes caused by i_start or i_collide sampled in cycle n are visible in cycle n+1.
- i_ani_stb is required to be a single-cycle pulse. Behaviour under a held strobe is one update per cycle, by design.
- Slot lifetime at speed 1: spawned on strobe k, with x = 659 under the defaults. It is retired on strobe k+659.

## Configuration
- **OBSTACLE_SPEEDUP_EN defined:**
  - Speed increments by 1 each time o_score crosses a multiple of 8, saturating at 4.
  - The retire test stays x ≤ speed, so x never wraps below 0.
- **OBSTACLE_SPEEDUP_EN undefined:**
  - Speed is the constant 1 and no speed register exists.
  - Score has no effect on motion.

## Structure
- **Package game_pkg** holds:
  - State encodings ST_IDLE / ST_RUN / ST_OVER.
  - Display constants D_WIDTH / D_HEIGHT.
  - MAX_SPEED = 4.
  - SPEEDUP_STEP = 8.
  - LFSR_TAPS = 16'hB400.
- **Sub-module lfsr16:** holds the 16-bit Galois LFSR, with clock, reset, seed parameter and 16-bit state output. It is reused by other game blocks.
- The slot pool is a generate loop over N_OBS.
- The free-slot selection is a priority encoder over the pre-strobe o_active.

## Test plan
- **Reset/start:** assert i_rst for 2 cycles, then i_start=1 for 1 cycle → o_state=1, o_active=0, o_score=0; no spawn before strobe 160.
- **First spawn:** after start, issue 160 strobes → on strobe 160, slot 0 active, x=659, 15 ≤ y ≤ 464; after strobe 161, x=658.
- **Retire/score:** continue to strobe 819 → slot 0 inactive, x=0, o_score=1.
- **Pool full:** N_OBS=4; spawns occur at strobes 160/320/480/640 into slots 0–3 → strobe 800 spawn is skipped (o_active=4'b1111 unchanged); strobe 960 respawns into slot 0.
- **Collision priority:** i_collide=1 together with i_ani_stb → next cycle o_state=2, positions unchanged; further strobes change nothing; i_start → IDLE with o_active=0.
- **Speedup:** with OBSTACLE_SPEEDUP_EN defined, force score to 8 → x steps by 2 per strobe.
  - A slot at x=2 retires on the next strobe.
  - Without the macro, the same stimulus steps x by 1.
